// File: rtl/median_window_3x3_pkg.sv
// Shared types for the 3x3 median window stage: window size, FSM state
// encoding and the slot index helper for the packed window bus.
package median_pkg;

    localparam int WIN_SIZE = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } win_state_t;

    // Slot number of neighbour (dy,dx) in the packed window, 0 = top-left.
    function automatic int win_idx(input int dy, input int dx);
        return 3 * dy + dx;
    endfunction

endpackage

// File: rtl/median_line_delay.sv
// One-line delay built on a RAM: dout is the sample written DEPTH shifts ago.
// The RAM is read before it is written at the same address, so a single
// pointer serves both ports. RAM contents are deliberately not reset.
module median_line_delay #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 640
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         ptr;

    assign dout = mem[ptr];

    // Store the incoming sample over the one being read out.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            mem[ptr] <= din;
        end
    end

    // Circular write/read pointer, advancing once per shift.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (shift_en) begin
            ptr <= (ptr == PTR_LAST) ? '0 : ptr + PW'(1);
        end
    end

endmodule

// File: rtl/median_window_3x3.sv
// 3x3 neighbourhood generator for the median filter. Two line delays feed a
// 3x3 shift register; one window is emitted per pixel position, with W+1
// self-generated flush cycles at end of frame so the bottom row comes out.
// Border handling: edge replication by default; zero padding when the macro
// MEDWIN_BORDER_ZERO_EN is defined.
//
// Handshake: a pixel is taken on a clk edge where in_valid && in_ready;
// in_ready is low only during FLUSH. The output has no backpressure:
// out_valid is a one-cycle pulse per window that must be consumed.
module median_window_3x3
    import median_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 512
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_WIDTH-1:0]          in_data,
    output logic                           out_valid,
    output logic [WIN_SIZE*DATA_WIDTH-1:0] out_win,
    output logic                           out_first,
    output logic                           out_last,
    output win_state_t                     dbg_state
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    win_state_t state, state_nx;
    logic [CW-1:0] in_col, ctr_col;
    logic [RW-1:0] in_row, ctr_row;
    logic accept, shift_en, emit, ctr_last;
    logic [DATA_WIDTH-1:0] pix, ld1_out, ld2_out;
    logic [DATA_WIDTH-1:0] t1, t2, m1, m2, b1, b2;
    logic [DATA_WIDTH-1:0] raw [3][3];
    logic [WIN_SIZE*DATA_WIDTH-1:0] win_c;
    logic row_top, row_bot, col_left, col_right;

    assign in_ready  = (state != FLUSH);
    assign accept    = in_valid && in_ready;
    assign shift_en  = accept || (state == FLUSH);
    assign emit      = (state == RUN && accept) || (state == FLUSH);
    assign pix       = (state == FLUSH) ? '0 : in_data;
    assign ctr_last  = (ctr_row == ROW_LAST) && (ctr_col == COL_LAST);
    assign dbg_state = state;

    median_line_delay #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_ld1 (
        .clk(clk), .rst_n(rst_n), .shift_en(shift_en), .din(pix), .dout(ld1_out)
    );
    median_line_delay #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_ld2 (
        .clk(clk), .rst_n(rst_n), .shift_en(shift_en), .din(ld1_out), .dout(ld2_out)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state: fill W+1 pixels, run to the last pixel, flush W+1 windows.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (accept) state_nx = FILL;
            FILL:  if (accept && in_row == ROW_ONE && in_col == '0) state_nx = RUN;
            RUN:   if (accept && in_row == ROW_LAST && in_col == COL_LAST) state_nx = FLUSH;
            FLUSH: if (ctr_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Raster position of the next pixel to accept and of the next centre.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_col  <= '0;
            in_row  <= '0;
            ctr_col <= '0;
            ctr_row <= '0;
        end else begin
            if (accept) begin
                in_col <= (in_col == COL_LAST) ? '0 : in_col + CW'(1);
                if (in_col == COL_LAST) in_row <= (in_row == ROW_LAST) ? '0 : in_row + RW'(1);
            end
            if (emit) begin
                ctr_col <= (ctr_col == COL_LAST) ? '0 : ctr_col + CW'(1);
                if (ctr_col == COL_LAST) ctr_row <= (ctr_row == ROW_LAST) ? '0 : ctr_row + RW'(1);
            end
        end
    end

    // Two oldest columns of the window; the newest column comes straight
    // from the input and the line-delay outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            t1 <= '0; t2 <= '0; m1 <= '0; m2 <= '0; b1 <= '0; b2 <= '0;
        end else if (shift_en) begin
            t1 <= t2; t2 <= ld2_out;
            m1 <= m2; m2 <= ld1_out;
            b1 <= b2; b2 <= pix;
        end
    end

    assign row_top   = (ctr_row == '0);
    assign row_bot   = (ctr_row == ROW_LAST);
    assign col_left  = (ctr_col == '0);
    assign col_right = (ctr_col == COL_LAST);

    // Window seen this cycle, with out-of-frame neighbours fixed up from
    // the centre position so no data from adjacent lines leaks in.
    always_comb begin
        raw[0][0] = t1; raw[0][1] = t2; raw[0][2] = ld2_out;
        raw[1][0] = m1; raw[1][1] = m2; raw[1][2] = ld1_out;
        raw[2][0] = b1; raw[2][1] = b2; raw[2][2] = pix;
        win_c = '0;
        for (int dy = 0; dy < 3; dy++) begin
            for (int dx = 0; dx < 3; dx++) begin
`ifdef MEDWIN_BORDER_ZERO_EN
                if ((dy == 0 && row_top) || (dy == 2 && row_bot) ||
                    (dx == 0 && col_left) || (dx == 2 && col_right))
                    win_c[DATA_WIDTH*win_idx(dy, dx) +: DATA_WIDTH] = '0;
                else
                    win_c[DATA_WIDTH*win_idx(dy, dx) +: DATA_WIDTH] = raw[dy][dx];
`else
                logic [1:0] sy, sx;
                sy = 2'(dy);
                sx = 2'(dx);
                if ((dy == 0 && row_top) || (dy == 2 && row_bot)) sy = 2'd1;
                if ((dx == 0 && col_left) || (dx == 2 && col_right)) sx = 2'd1;
                win_c[DATA_WIDTH*win_idx(dy, dx) +: DATA_WIDTH] = raw[sy][sx];
`endif
            end
        end
    end

    // Registered output: one pulse per emitted window, window held otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            out_win   <= '0;
        end else begin
            out_valid <= emit;
            out_first <= emit && row_top && col_left;
            out_last  <= emit && ctr_last;
            if (emit) out_win <= win_c;
        end
    end

endmodule

// File: doc/median_window_3x3.md
Name: median_window_3x3

Overview:
- Downstream consumer of the median-filter line-delay stage.
- Accepts a raster pixel stream of one frame (IMG_WIDTH x IMG_HEIGHT).
- Internally holds two line delays plus a 3x3 shift register, and emits one 3x3 neighbourhood per input pixel position, with border handling, to the median sorting network.
- Generates its own flush cycles at end of frame so the bottom row is also emitted.

Parameters:
DATA_WIDTH, 8, pixel width in bits
IMG_WIDTH, 640, pixels per line (>=3)
IMG_HEIGHT, 512, lines per frame (>=2)

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
in_valid  input  1  input pixel valid; a pixel is accepted when in_valid && in_ready
in_ready  output  1  block can accept a pixel
in_data  input  DATA_WIDTH  input pixel, raster order
out_valid  output  1  out_win valid, one cycle per window
out_win  output  9*DATA_WIDTH  window; slot k=3*dy+dx at [DATA_WIDTH*k +: DATA_WIDTH]; k=0 top-left, k=4 centre, k=8 bottom-right
out_first  output  1  qualifies window centred at (0,0)
out_last  output  1  qualifies window centred at (H-1,W-1)

Behaviour:
- Reset values: out_valid=0, out_first=0, out_last=0, out_win=0, in_ready=1, state=IDLE, all counters 0. Line-delay RAM contents are not reset.
- Reset mid-frame: all partial-frame state is discarded. Stale RAM data is never used, because top-border handling masks row -1.
- States:
  - IDLE: in_ready=1. First accepted pixel -> FILL.
  - FILL: in_ready=1, no output. After W+1 pixels accepted in total -> RUN.
  - RUN: in_ready=1. Each accepted pixel with raster index p emits the window centred at index p-(W+1).
  - Acceptance of index H*W-1 -> FLUSH.
  - FLUSH: in_ready=0. Exactly W+1 internal pseudo-accept cycles, one per clk, each emitting one window. The last one asserts out_last -> IDLE next cycle.
- Latency: out_valid is registered and asserts on the clk edge after the triggering accept or flush cycle.
- Upstream stalls: in_valid=0 in FILL/RUN stalls all shifting; out_valid=0 on those cycles.
- Downstream: no backpressure; the consumer must accept every out_valid cycle.
- Counters:
  - in_col 0..W-1, in_row 0..H-1 track accepts; wrap col->0 and row++ at W-1.
  - ctr_col/ctr_row track the emitted centre.
  - Counter widths are $clog2(W) and $clog2(H).
- Border handling (default, replicate): any neighbour with row<0, row>H-1, col<0 or col>W-1 takes the value of the clamped coordinate within the same window, i.e. it duplicates the nearest edge row/column of the window. Selection is driven by ctr_row/ctr_col, so no cross-line data leaks in at left/right edges.
- out_first=1 only with the centre at (0,0); out_last=1 only with the centre at (H-1,W-1). Both are qualified by out_valid.
- in_valid asserted during FLUSH is ignored (not accepted).
- Back-to-back frames: the first pixel of the next frame is accepted on the cycle after out_last.

Optional Feature:
- MEDWIN_BORDER_ZERO_EN:
  - Defined: out-of-frame neighbours are 0 (zero padding).
  - Undefined: edge replication as above.
- Counters, latency and flags are identical in both modes.

Decomposition:
- Package median_pkg holds:
  - localparam WIN_SIZE=9
  - typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} win_state_t
  - function win_idx(dy,dx) returning 3*dy+dx
- One sub-module, median_line_delay: a RAM-based delay of IMG_WIDTH accepted samples with a shift-enable. It is instantiated twice in series.

Test Plan:
- W=4, H=3, pixel value = raster index, in_valid always 1 -> 12 out_valid pulses. First is 6 cycles after the first accept: out_win=[0,0,1, 0,0,1, 4,4,5], out_first=1.
- Same frame, centre (1,1)=5 -> [0,1,2, 4,5,6, 8,9,10]. Centre (0,3)=3 -> [2,3,3, 2,3,3, 6,7,7].
- Same frame, last window -> [6,7,7, 10,11,11, 10,11,11], out_last=1. in_ready=0 for exactly 5 cycles before it.
- MEDWIN_BORDER_ZERO_EN defined, same frame -> first [0,0,0, 0,0,1, 0,4,5]; last [6,7,0, 10,11,0, 0,0,0].
- Random in_valid gaps (50%) plus two back-to-back frames -> windows identical to the gap-free reference model. No out_valid during stalls. Second frame's out_first follows first frame's out_last.
- rst_n pulsed low after 7 pixels, then a full frame sent -> no stale output; first window equals the fresh-frame result above.
